window_sum_stage: RTL

Downstream consumer of the BRAM-packed line-buffer top. Each cycle the line buffer asserts SM_EN, it presents one K-pixel image column: X packed instances of four rows each, plus the single external-memory row. This block assembles those columns into a sliding K×K window, computes the window sum, and emits one result per valid window position with row and frame bookkeeping. It is driven by the same start/complete sequencing as the line buffer.

---
 rtl/window_sum_stage_if.sv | 30 +++
 rtl/window_sum_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/window_sum_stage_if.sv
// Column-in / window-out bundle between the line buffer and window_sum_stage.
//
// Handshake: there is no back-pressure. A column is transferred on every
// rising CLK edge where col_valid is high and the stage is in RUN.
// win_valid marks the single cycle in which win_sum, center_px and row_done
// carry a result. start and complete are one-cycle pulses.
interface window_sum_stage_if #(
  parameter int K  = 5,
  parameter int SW = 8 + $clog2(K * K)
);
  logic           start;
  logic           col_valid;
  logic [8*K-1:0] col_in;
  logic           win_valid;
  logic [SW-1:0]  win_sum;
  logic [7:0]     center_px;
  logic           row_done;
  logic           complete;
  logic           busy;

  modport master (
    output start, col_valid, col_in,
    input  win_valid, win_sum, center_px, row_done, complete, busy
  );

  modport slave (
    input  start, col_valid, col_in,
    output win_valid, win_sum, center_px, row_done, complete, busy
  );
endinterface

// File: rtl/window_sum_stage.sv
// Sliding KxK window sum over columns delivered by the line buffer.
// Stage 1 reduces each accepted column to a column sum and shifts it into a
// K-deep register; stage 2 adds those K entries into the window sum.
// A small FSM tracks column/row position and frame start/end.
module window_sum_stage #(
  parameter int K     = 5,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int SW    = 8 + $clog2(K * K)
) (
  input  logic              CLK,
  input  logic              rst,
  window_sum_stage_if.slave bus,
  output logic [1:0]        dbg_state
);

  localparam int OUT_ROWS = IMG_H - K + 1;
  localparam int CW       = 8 + $clog2(K);
  localparam int CCW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RCW      = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  // Byte 0 is the newest row (out5); bytes 1..K-1 hold the older rows in
  // order, so the middle image row sits one byte above (K-1)/2.
  localparam int MID_BYTE = (K - 1) / 2 + 1;
  localparam int MID_COL  = (K - 1) / 2;
  localparam logic [CCW-1:0] COL_LAST = CCW'(IMG_W - 1);
  localparam logic [RCW-1:0] ROW_LAST = RCW'(OUT_ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t   state_q, state_d;
  logic     drain_cnt_q, drain_cnt_d;
  logic [CCW-1:0] col_cnt_q, col_cnt_d;
  logic [RCW-1:0] row_cnt_q, row_cnt_d;
  logic     accept;
  logic     clear_sr;

  // stage 1 state
  logic [K-1:0][CW-1:0] colsum_sr_q, colsum_sr_d;
  logic [K-1:0][7:0]    pix_sr_q, pix_sr_d;
  logic                 s1_fire_q, s1_fire_d;
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_last_q, s1_last_d;
  logic [CW-1:0]        colsum;

  // stage 2 state
  logic          win_valid_q, win_valid_d;
  logic          row_done_q, row_done_d;
  logic [SW-1:0] win_sum_q, win_sum_d;
  logic [7:0]    center_q, center_d;
  logic [SW-1:0] win_acc;

  // Frame sequencing: position counters and IDLE/RUN/DRAIN/DONE transitions.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    accept      = 1'b0;
    clear_sr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_RUN;
          col_cnt_d = '0;
          row_cnt_d = '0;
          clear_sr  = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.col_valid) begin
          accept = 1'b1;
          if (col_cnt_q == COL_LAST) begin
            col_cnt_d = '0;
            if (row_cnt_q == ROW_LAST) begin
              state_d     = S_DRAIN;
              drain_cnt_d = 1'b0;
            end else begin
              row_cnt_d = row_cnt_q + 1'b1;
            end
          end else begin
            col_cnt_d = col_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Column reduction: zero-extended sum of the K bytes of the incoming column.
  always_comb begin
    colsum = '0;
    for (int i = 0; i < K; i++) begin
      colsum = colsum + CW'(bus.col_in[8*i +: 8]);
    end
  end

  // Stage 1: shift column sum and middle-row pixel; tag window validity.
  always_comb begin
    colsum_sr_d = colsum_sr_q;
    pix_sr_d    = pix_sr_q;
    s1_fire_d   = accept;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    if (clear_sr) begin
      colsum_sr_d = '0;
      pix_sr_d    = '0;
      s1_valid_d  = 1'b0;
      s1_last_d   = 1'b0;
    end else if (accept) begin
      colsum_sr_d = {colsum_sr_q[K-2:0], colsum};
      pix_sr_d    = {pix_sr_q[K-2:0], bus.col_in[8*MID_BYTE +: 8]};
      // Only K fresh columns of the current row make a reportable window.
      s1_valid_d  = (int'(col_cnt_q) >= K - 1);
      s1_last_d   = (col_cnt_q == COL_LAST);
    end
  end

  // Window adder over the K column-sum entries.
  always_comb begin
    win_acc = '0;
    for (int i = 0; i < K; i++) begin
      win_acc = win_acc + SW'(colsum_sr_q[i]);
    end
  end

  // Stage 2: register the window result one cycle after stage 1 fired.
  always_comb begin
    win_valid_d = s1_fire_q & s1_valid_q;
    row_done_d  = s1_fire_q & s1_valid_q & s1_last_q;
    win_sum_d   = win_sum_q;
    center_d    = center_q;
    if (s1_fire_q) begin
      win_sum_d = win_acc;
      center_d  = pix_sr_q[MID_COL];
    end
  end

  // State, counters and both pipeline stages; reset abandons any frame.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= 1'b0;
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      colsum_sr_q <= '0;
      pix_sr_q    <= '0;
      s1_fire_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      win_valid_q <= 1'b0;
      row_done_q  <= 1'b0;
      win_sum_q   <= '0;
      center_q    <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      colsum_sr_q <= colsum_sr_d;
      pix_sr_q    <= pix_sr_d;
      s1_fire_q   <= s1_fire_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      win_valid_q <= win_valid_d;
      row_done_q  <= row_done_d;
      win_sum_q   <= win_sum_d;
      center_q    <= center_d;
    end
  end

  assign bus.win_valid = win_valid_q;
  assign bus.win_sum   = win_sum_q;
  assign bus.center_px = center_q;
  assign bus.row_done  = row_done_q;
  assign bus.complete  = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign dbg_state     = state_q;

endmodule
